// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel status LED controller.
// A shared 1 kHz timebase drives SLOW/FAST blinking, a shared 8-bit counter
// drives PWM dimming, and each channel runs its own BURST pulse-code FSM.
module led_ctrl #(
    parameter int C_CLK_FREQ       = 100000000,
    parameter int C_CHANNELS       = 4,
    parameter int C_PWM_DIV        = 16,
    parameter bit C_LED_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [3:0]            cfg_ch,
    input  logic [2:0]            cfg_mode,
    input  logic [7:0]            cfg_arg,
    output logic [C_CHANNELS-1:0] led
);

    localparam int unsigned PRESC_MAX = C_CLK_FREQ / 1000 - 1;
    localparam int unsigned PWM_MAX   = C_PWM_DIV - 1;

    typedef enum logic [2:0] {
        M_OFF   = 3'd0,
        M_ON    = 3'd1,
        M_SLOW  = 3'd2,
        M_FAST  = 3'd3,
        M_PWM   = 3'd4,
        M_BURST = 3'd5
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_P_ON,
        S_P_OFF,
        S_GAP
    } burst_state_t;

    logic [31:0]     presc;
    logic            tick;
    logic [9:0]      ms_cnt;
    logic [31:0]     div_cnt;
    logic            pwm_step;
    logic [7:0]      pwm_cnt;

    logic [2:0]      mode  [C_CHANNELS];
    logic [7:0]      arg   [C_CHANNELS];
    burst_state_t    state [C_CHANNELS];
    logic [3:0]      rem   [C_CHANNELS];
    logic [9:0]      tcnt  [C_CHANNELS];

    logic [C_CHANNELS-1:0] lit;

    assign tick     = (presc == PRESC_MAX);
    assign pwm_step = (div_cnt == PWM_MAX);

    // 1 kHz tick prescaler and the shared millisecond counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (tick) begin
            presc  <= '0;
            ms_cnt <= (ms_cnt == 10'd999) ? '0 : ms_cnt + 10'd1;
        end else begin
            presc  <= presc + 32'd1;
        end
    end

    // PWM step divider and the free-running 8-bit PWM counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else if (pwm_step) begin
            div_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            div_cnt <= div_cnt + 32'd1;
        end
    end

    // Per-channel config registers and BURST FSMs; a write to a channel
    // takes priority over a coincident tick for that channel only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                mode[i]  <= M_OFF;
                arg[i]   <= '0;
                state[i] <= S_IDLE;
                rem[i]   <= '0;
                tcnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                if (cfg_wr && (cfg_ch == 4'(i))) begin
                    mode[i]  <= cfg_mode;
                    arg[i]   <= cfg_arg;
                    rem[i]   <= cfg_arg[3:0];
                    tcnt[i]  <= '0;
                    state[i] <= ((cfg_mode == M_BURST) && (cfg_arg[3:0] != '0)) ? S_P_ON : S_IDLE;
                end else if (mode[i] != M_BURST) begin
                    state[i] <= S_IDLE;
                    tcnt[i]  <= '0;
                end else if (tick) begin
                    case (state[i])
                        S_P_ON: begin
                            if (tcnt[i] == 10'd199) begin
                                state[i] <= S_P_OFF;
                                rem[i]   <= rem[i] - 4'd1;
                                tcnt[i]  <= '0;
                            end else begin
                                tcnt[i]  <= tcnt[i] + 10'd1;
                            end
                        end
                        S_P_OFF: begin
                            if (tcnt[i] == 10'd199) begin
                                state[i] <= (rem[i] != '0) ? S_P_ON : S_GAP;
                                tcnt[i]  <= '0;
                            end else begin
                                tcnt[i]  <= tcnt[i] + 10'd1;
                            end
                        end
                        S_GAP: begin
                            if (tcnt[i] == 10'd799) begin
                                state[i] <= S_P_ON;
                                rem[i]   <= arg[i][3:0];
                                tcnt[i]  <= '0;
                            end else begin
                                tcnt[i]  <= tcnt[i] + 10'd1;
                            end
                        end
                        default: begin
                            tcnt[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Lit state per channel from its mode and the shared timebases
    always_comb begin
        lit = '0;
        for (int unsigned i = 0; i < C_CHANNELS; i++) begin
            case (mode[i])
                M_ON:    lit[i] = 1'b1;
                M_SLOW:  lit[i] = (ms_cnt < 10'd500);
                M_FAST:  lit[i] = ((ms_cnt % 10'd250) < 10'd125);
                M_PWM:   lit[i] = (pwm_cnt < arg[i]);
                M_BURST: lit[i] = (state[i] == S_P_ON);
                default: lit[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= {C_CHANNELS{C_LED_ACTIVE_LOW}};
        end else begin
            led <= lit ^ {C_CHANNELS{C_LED_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed, table-driven bench for led_ctrl (active-low LEDs,
// 10 clk per tick, PWM step every clk).
module tb_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_wr;
    logic [3:0] cfg_ch;
    logic [2:0] cfg_mode;
    logic [7:0] cfg_arg;
    logic [3:0] led;
    logic [3:0] lit;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    assign lit = ~led;

    led_ctrl #(
        .C_CLK_FREQ      (10000),
        .C_CHANNELS      (4),
        .C_PWM_DIV       (1),
        .C_LED_ACTIVE_LOW(1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_arg (cfg_arg),
        .led     (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ch;
        logic [2:0]  mode;
        logic [7:0]  arg;
        int unsigned obs;
        int unsigned exp_hi;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [2:0] mode, input logic [7:0] arg);
        @(negedge clk);
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_arg  = arg;
        cfg_wr   = 1'b1;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    initial begin
        int unsigned hi_cnt;
        int unsigned hi0, hi1, tog1, first_low0;
        int unsigned run;
        logic        found, p0, p1, c1, all_ok, cur_val;
        int unsigned hi_runs[$];
        int unsigned lo_runs[$];

        vecs[0]  = '{4'd0,  3'd1, 8'd0,   0, 256};
        vecs[1]  = '{4'd0,  3'd0, 8'd0,   0, 0};
        vecs[2]  = '{4'd7,  3'd1, 8'd0,   0, 0};
        vecs[3]  = '{4'd1,  3'd1, 8'd0,   1, 256};
        vecs[4]  = '{4'd1,  3'd6, 8'd0,   1, 0};
        vecs[5]  = '{4'd1,  3'd1, 8'd0,   1, 256};
        vecs[6]  = '{4'd1,  3'd7, 8'd0,   1, 0};
        vecs[7]  = '{4'd2,  3'd4, 8'd64,  2, 64};
        vecs[8]  = '{4'd2,  3'd4, 8'd0,   2, 0};
        vecs[9]  = '{4'd2,  3'd4, 8'd255, 2, 255};
        vecs[10] = '{4'd2,  3'd4, 8'd128, 2, 128};
        vecs[11] = '{4'd3,  3'd5, 8'd1,   3, 256};
        vecs[12] = '{4'd3,  3'd5, 8'h30,  3, 0};
        vecs[13] = '{4'd3,  3'd5, 8'd0,   3, 0};
        vecs[14] = '{4'd1,  3'd1, 8'd0,   1, 256};
        vecs[15] = '{4'd15, 3'd0, 8'd0,   1, 256};
        vecs[16] = '{4'd4,  3'd0, 8'd0,   1, 256};

        rst_n    = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_mode = '0;
        cfg_arg  = '0;

        // reset: all dark on an active-low board
        #23;
        check("reset_led", led, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        all_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (led != 4'b1111) all_ok = 1'b0;
        end
        check("idle_after_reset", all_ok, 1);

        // table: static modes, PWM duty, ignored channels
        foreach (vecs[k]) begin
            cfg_write(vecs[k].ch, vecs[k].mode, vecs[k].arg);
            @(negedge clk);
            hi_cnt = 0;
            repeat (256) begin
                @(negedge clk);
                if (lit[vecs[k].obs]) hi_cnt++;
            end
            check($sformatf("vec%0d_hi_count", k), hi_cnt, vecs[k].exp_hi);
        end

        // SLOW / FAST alignment
        cfg_write(4'd0, 3'd2, 8'd0);
        cfg_write(4'd1, 3'd3, 8'd0);
        found = 1'b0;
        p0 = lit[0];
        p1 = lit[1];
        c1 = lit[1];
        for (int n = 0; n < 11000 && !found; n++) begin
            @(negedge clk);
            if (!p0 && lit[0]) begin
                found = 1'b1;
                c1 = lit[1];
            end else begin
                p0 = lit[0];
                p1 = lit[1];
            end
        end
        check("slow_rise_found", found, 1);
        check("fast_rise_aligned", {p1, c1}, 2'b01);
        hi0 = 1; hi1 = 1; tog1 = 0; first_low0 = 0;
        p1 = lit[1];
        for (int j = 1; j < 10000; j++) begin
            @(negedge clk);
            if (lit[0]) hi0++;
            else if (first_low0 == 0) first_low0 = j;
            if (lit[1]) hi1++;
            if (lit[1] != p1) tog1++;
            p1 = lit[1];
        end
        check("slow_high_cycles", hi0, 5000);
        check("slow_first_low", first_low0, 5000);
        check("fast_high_cycles", hi1, 5000);
        check("fast_toggles", tog1, 7);
        @(negedge clk);
        check("both_rise_next_period", {lit[1], lit[0]}, 2'b11);

        // write coincident with tick: the tick edge lies 1 clk before this rise
        repeat (7) @(negedge clk);
        cfg_write(4'd3, 3'd5, 8'd1);
        run = 0;
        for (int n = 0; n < 2100; n++) begin
            @(negedge clk);
            if (lit[3]) run++;
            else if (run > 0) break;
        end
        check("coincident_pon_len", run, 2000);

        // BURST count 3 over three frames
        cfg_write(4'd3, 3'd5, 8'd3);
        @(negedge clk);
        check("burst_first_lit", lit[3], 1);
        cur_val = 1'b1;
        run = 1;
        repeat (60500) begin
            @(negedge clk);
            if (lit[3] == cur_val) run++;
            else begin
                if (cur_val) hi_runs.push_back(run);
                else lo_runs.push_back(run);
                cur_val = lit[3];
                run = 1;
            end
        end
        check("burst_hi_runs_seen", (hi_runs.size() >= 9) ? 1 : 0, 1);
        check("burst_lo_runs_seen", (lo_runs.size() >= 9) ? 1 : 0, 1);
        if (hi_runs.size() >= 9 && lo_runs.size() >= 9) begin
            check("burst_first_on_range", (hi_runs[0] >= 1991 && hi_runs[0] <= 2000) ? 1 : 0, 1);
            for (int k = 1; k < 9; k++)
                check($sformatf("burst_on%0d", k), hi_runs[k], 2000);
            for (int k = 0; k < 9; k++)
                check($sformatf("burst_off%0d", k), lo_runs[k], (k % 3 == 2) ? 10000 : 2000);
        end

        // reset mid-burst
        cfg_write(4'd3, 3'd5, 8'd2);
        repeat (100) @(negedge clk);
        check("midburst_lit", lit[3], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_dark", led, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hi_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (lit != 4'b0000) hi_cnt++;
        end
        check("config_cleared", hi_cnt, 0);
        cfg_write(4'd3, 3'd1, 8'd0);
        @(negedge clk);
        check("rewrite_after_reset", lit, 4'b1000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
